// File: rtl/switch_debounce.sv
// Slide-switch conditioner: two-flop synchronizer per bit, a shared sample-tick
// prescaler and per-bit stability counters producing a clean switch vector.
module switch_debounce #(
    parameter int               WIDTH        = 8,
    parameter int               TICK_DIV     = 50000,
    parameter int               STABLE_TICKS = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] slideswitch,
    output logic [WIDTH-1:0] switches,
    output logic             sw_changed,
    output logic [WIDTH-1:0] changed_mask,
    output logic             settled
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS + 1) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync_ff;
    logic [PW-1:0]    pre_count;
    logic             tick;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] update_mask;
    logic [WIDTH-1:0] cnt_busy;

    assign tick    = (pre_count == TICK_LAST);
    assign settled = ~|cnt_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= RESET_VALUE;
            sync_ff   <= RESET_VALUE;
        end else begin
            sync_meta <= slideswitch;
            sync_ff   <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_count <= '0;
        end else if (tick) begin
            pre_count <= '0;
        end else begin
            pre_count <= pre_count + PW'(1);
        end
    end

    // A bit is accepted on the tick that would otherwise push its count to STABLE_TICKS.
    always_comb begin
        update_mask = '0;
        cnt_busy    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_busy[i]    = (cnt[i] != '0);
            update_mask[i] = tick && (sync_ff[i] != switches[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_ff[i] == switches[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            switches     <= RESET_VALUE;
            sw_changed   <= 1'b0;
            changed_mask <= '0;
        end else begin
            switches     <= (switches & ~update_mask) | (sync_ff & update_mask);
            sw_changed   <= |update_mask;
            changed_mask <= update_mask;
        end
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce with a 4-cycle tick and 3-tick stability.
module tb_switch_debounce;

    localparam int WIDTH        = 8;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_TICKS = 3;

    typedef struct packed {
        logic [WIDTH-1:0] sw;
        logic [WIDTH-1:0] mask;
    } exp_t;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] slideswitch;
    logic [WIDTH-1:0] switches;
    logic             sw_changed;
    logic [WIDTH-1:0] changed_mask;
    logic             settled;

    exp_t expQueue [$];
    int   assertCount = 0;
    int   failCount   = 0;

    switch_debounce #(
        .WIDTH       (WIDTH),
        .TICK_DIV    (TICK_DIV),
        .STABLE_TICKS(STABLE_TICKS),
        .RESET_VALUE ('0)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .slideswitch (slideswitch),
        .switches    (switches),
        .sw_changed  (sw_changed),
        .changed_mask(changed_mask),
        .settled     (settled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives the switches just after an edge and queues the pulse it should cause.
    task automatic applyStimulus(input logic [WIDTH-1:0] value, input bit expectPulse,
                                 input logic [WIDTH-1:0] expSw, input logic [WIDTH-1:0] expMask);
        exp_t e;
        slideswitch = value;
        if (expectPulse) begin
            e.sw   = expSw;
            e.mask = expMask;
            expQueue.push_back(e);
        end
    endtask

    // Leaves the bench 1 time unit after the release edge with slideswitch = value.
    task automatic applyReset(input logic [WIDTH-1:0] value);
        @(posedge clk);
        #1;
        reset_n     = 1'b0;
        slideswitch = value;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic waitUpdate(input string name, input logic [WIDTH-1:0] expSw, input int expLat);
        int lat;
        bit hit;
        lat = 0;
        hit = 0;
        while (!hit && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (switches == expSw) hit = 1;
        end
        checkOutput({name, "_switches"}, 32'(switches), 32'(expSw));
        checkOutput({name, "_latency"}, 32'(lat), 32'(expLat));
    endtask

    // Monitor: every pulse must match the head of the queue; idle cycles carry an empty mask.
    always @(negedge clk) begin
        if (reset_n) begin
            if (sw_changed) begin
                if (expQueue.size() == 0) begin
                    assertCount++;
                    failCount++;
                    $display("[TB] FAIL unexpected_pulse: got mask %0h, required no pulse at %0t",
                             changed_mask, $time);
                end else begin
                    exp_t e;
                    e = expQueue.pop_front();
                    checkOutput("pulse_switches", 32'(switches), 32'(e.sw));
                    checkOutput("pulse_mask", 32'(changed_mask), 32'(e.mask));
                end
            end else begin
                checkOutput("idle_mask", 32'(changed_mask), 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int tickTimes [$];
        int phaseLat [4];
        phaseLat[0] = 12;
        phaseLat[1] = 11;
        phaseLat[2] = 14;
        phaseLat[3] = 13;

        reset_n     = 1'b1;
        slideswitch = 8'hFF;
        #3 reset_n  = 1'b0;

        $display("[TB] test 1: reset and release with all switches high");
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_switches", 32'(switches), 32'h00);
        checkOutput("reset_sw_changed", 32'(sw_changed), 32'h0);
        checkOutput("reset_settled", 32'(settled), 32'h1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(8'hFF, 1'b1, 8'hFF, 8'hFF);
        waitUpdate("t1", 8'hFF, 12);

        $display("[TB] test 2: single short glitch on bit 0");
        applyReset(8'h00);
        applyStimulus(8'h01, 1'b0, 8'h00, 8'h00);
        repeat (5) @(posedge clk);
        #1;
        applyStimulus(8'h00, 1'b0, 8'h00, 8'h00);
        repeat (6) @(posedge clk);
        @(negedge clk);
        checkOutput("t2_settled", 32'(settled), 32'h1);
        checkOutput("t2_switches", 32'(switches), 32'h00);

        $display("[TB] test 3: bouncing bit 3");
        applyReset(8'h00);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(slideswitch ^ 8'h08, 1'b0, 8'h00, 8'h00);
            repeat (3) @(posedge clk);
            #1;
        end
        applyStimulus(8'h08, 1'b1, 8'h08, 8'h08);
        waitUpdate("t3", 8'h08, 14);

        $display("[TB] test 4: bits 1 and 6 together");
        applyReset(8'h00);
        applyStimulus(8'h42, 1'b1, 8'h42, 8'h42);
        waitUpdate("t4", 8'h42, 12);

        $display("[TB] test 5: reset during a pending count");
        applyReset(8'h00);
        applyStimulus(8'h04, 1'b0, 8'h00, 8'h00);
        repeat (8) @(posedge clk);
        @(negedge clk);
        checkOutput("t5_pending_settled", 32'(settled), 32'h0);
        checkOutput("t5_pending_switches", 32'(switches), 32'h00);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("t5_reset_switches", 32'(switches), 32'h00);
        checkOutput("t5_reset_sw_changed", 32'(sw_changed), 32'h0);
        checkOutput("t5_reset_settled", 32'(settled), 32'h1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(8'h04, 1'b1, 8'h04, 8'h04);
        waitUpdate("t5", 8'h04, 12);

        $display("[TB] test 6: prescaler period and latency across phases");
        applyReset(8'h00);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (dut.tick) tickTimes.push_back(c);
        end
        checkOutput("t6_tick_count", 32'(tickTimes.size()), 32'd10);
        if (tickTimes.size() > 0) begin
            checkOutput("t6_first_tick", 32'(tickTimes[0]), 32'(TICK_DIV - 1));
        end
        for (int i = 1; i < tickTimes.size(); i++) begin
            checkOutput("t6_tick_period", 32'(tickTimes[i] - tickTimes[i-1]), 32'(TICK_DIV));
        end
        for (int p = 0; p < 4; p++) begin
            applyReset(8'h00);
            repeat (p) begin
                @(posedge clk);
                #1;
            end
            applyStimulus(8'h80, 1'b1, 8'h80, 8'h80);
            waitUpdate($sformatf("t6_phase%0d", p), 8'h80, phaseLat[p]);
        end

        repeat (20) @(posedge clk);
        @(negedge clk);
        checkOutput("queue_empty", 32'(expQueue.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
